// File: rtl/adder_pipe.sv
// Pipelined add/subtract unit with valid/ready handshake and a stall-all pipeline.
// Optional sticky carry/borrow flag is built when ADDER_PIPE_OVF_EN is defined.
module adder_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum
`ifdef ADDER_PIPE_OVF_EN
    ,
    output logic             ovf_sticky
`endif
);

    logic [STAGES:1]          vld_pipe;
    logic [STAGES:1][WIDTH:0] res_pipe;
    logic                     adv;
    logic [WIDTH:0]           res_in;

    // The whole chain moves together; any stall at the tail freezes every stage.
    assign adv       = !vld_pipe[STAGES] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_pipe[STAGES];
    assign sum       = res_pipe[STAGES];

    always_comb begin
        res_in = '0;
        if (op) res_in = {1'b0, a} - {1'b0, b};
        else    res_in = {1'b0, a} + {1'b0, b};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            res_pipe <= '0;
        end else if (adv) begin
            vld_pipe[1] <= in_valid;
            res_pipe[1] <= res_in;
            for (int i = 2; i <= STAGES; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                res_pipe[i] <= res_pipe[i-1];
            end
        end
    end

`ifdef ADDER_PIPE_OVF_EN
    always_ff @(posedge clk) begin
        if (!rst_n)                                ovf_sticky <= 1'b0;
        else if (out_valid && out_ready && sum[WIDTH]) ovf_sticky <= 1'b1;
    end
`endif

endmodule
